// File: rtl/conv1d_ctrl.sv
// conv1d_ctrl: sequences a K_TAPS-PE 1-D convolution chain (weight load, feature stream, drain, done).
// Define CONV1D_CTRL_PAD_EN to add (K_TAPS-1)/2 zero pad beats before and after the feature run.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module conv1d_ctrl #(
  parameter int K_TAPS   = 3,
  parameter int LEN_W    = 10,
  parameter int PIPE_LAT = 2*K_TAPS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic [`WIDTH_DATA-1:0]   w_data,
  input  logic                     w_vld,
  output logic                     w_rdy,
  input  logic [`WIDTH_DATA-1:0]   fm_data,
  input  logic                     fm_vld,
  output logic                     fm_rdy,
  output logic [`WIDTH_DATA-1:0]   pe_w_data,
  output logic [K_TAPS-1:0]        pe_w_valid,
  output logic [`WIDTH_DATA-1:0]   pe_fm_data,
  input  logic [2*`WIDTH_DATA-1:0] pe_psum,
  output logic [2*`WIDTH_DATA-1:0] out_data,
  output logic                     out_vld,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = LEN_W + 1;
  localparam int WC_W  = $clog2(K_TAPS + 1);
  localparam int DR_W  = $clog2(PIPE_LAT + 1);
`ifdef CONV1D_CTRL_PAD_EN
  localparam int PAD   = (K_TAPS - 1) / 2;
`endif

  // state    | meaning
  // IDLE     | waiting for start with a legal len
  // LOAD_W   | accepting K_TAPS weights, one PE strobe each
  // STREAM   | issuing N_IN beats (pads and features) into PE[0]
  // DRAIN    | flushing the chain for PIPE_LAT cycles
  // DONE     | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                   state_q;
  logic [LEN_W-1:0]         len_q;
  logic [WC_W-1:0]          w_cnt_q;
  logic [CNT_W-1:0]         beat_cnt_q;
  logic [DR_W-1:0]          drain_q;
  logic [PIPE_LAT-1:0]      tag_q, tag_d;
  logic [2*`WIDTH_DATA-1:0] out_data_q;
  logic                     busy_q, done_q, err_q, w_rdy_q;

  logic                     len_ok, is_pad, in_stream, feat_slot, gap;
  logic                     issue, last_beat, tag_in, w_take;
  logic [CNT_W-1:0]         n_in;

  always_comb begin
`ifdef CONV1D_CTRL_PAD_EN
    len_ok = (len != '0);
    n_in   = CNT_W'(len_q) + CNT_W'(2*PAD);
    is_pad = (beat_cnt_q < CNT_W'(PAD)) ||
             (beat_cnt_q >= CNT_W'(len_q) + CNT_W'(PAD));
`else
    len_ok = (CNT_W'(len) >= CNT_W'(K_TAPS));
    n_in   = CNT_W'(len_q);
    is_pad = 1'b0;
`endif
  end

  assign in_stream = (state_q == S_STREAM);
  assign feat_slot = in_stream && !is_pad;
  assign gap       = feat_slot && !fm_vld;
  // A gap cycle issues no beat: the feature slot is retried next cycle.
  assign issue     = in_stream && (is_pad || fm_vld);
  assign last_beat = issue && (beat_cnt_q == n_in - CNT_W'(1));
  assign tag_in    = issue && (beat_cnt_q >= CNT_W'(K_TAPS - 1));
  assign w_take    = w_rdy_q && w_vld;

  assign w_rdy      = w_rdy_q;
  assign fm_rdy     = feat_slot;
  assign pe_w_valid = w_take ? (K_TAPS'(1) << w_cnt_q) : '0;
  assign pe_w_data  = w_take ? w_data : '0;
  assign pe_fm_data = (feat_slot && fm_vld) ? fm_data : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q || gap;
  assign out_vld    = tag_q[PIPE_LAT-1];
  assign out_data   = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      w_cnt_q    <= '0;
      beat_cnt_q <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      w_rdy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_q    <= S_LOAD_W;
              len_q      <= len;
              w_cnt_q    <= '0;
              beat_cnt_q <= '0;
              drain_q    <= '0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              w_rdy_q    <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (w_take) begin
            if (w_cnt_q == WC_W'(K_TAPS - 1)) begin
              state_q <= S_STREAM;
              w_rdy_q <= 1'b0;
            end else begin
              w_cnt_q <= w_cnt_q + WC_W'(1);
            end
          end
        end
        S_STREAM: begin
          if (gap) err_q <= 1'b1;
          if (issue) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (last_beat) begin
              state_q <= S_DRAIN;
              drain_q <= DR_W'(PIPE_LAT - 1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DR_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          w_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // out_vld is the last stage of the tag line; out_data captures the psum alongside it.
  assign tag_d = (tag_q << 1) | PIPE_LAT'(tag_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      out_data_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (tag_d[PIPE_LAT-1]) out_data_q <= pe_psum;
    end
  end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Randomized self-checking bench for conv1d_ctrl; a behavioural PE-chain stand-in drives pe_psum.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module tb_conv1d_ctrl;

  localparam int K  = 3;
  localparam int LW = 10;
  localparam int PL = 2*K;
  localparam int DW = `WIDTH_DATA;
`ifdef CONV1D_CTRL_PAD_EN
  localparam int P = (K-1)/2;
`else
  localparam int P = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [LW-1:0]   len = '0;
  logic [DW-1:0]   w_data = '0;
  logic            w_vld = 1'b0;
  logic            w_rdy;
  logic [DW-1:0]   fm_data = '0;
  logic            fm_vld = 1'b0;
  logic            fm_rdy;
  logic [DW-1:0]   pe_w_data;
  logic [K-1:0]    pe_w_valid;
  logic [DW-1:0]   pe_fm_data;
  logic [2*DW-1:0] pe_psum = '0;
  logic [2*DW-1:0] out_data;
  logic            out_vld;
  logic            busy, done, err;

  conv1d_ctrl #(.K_TAPS(K), .LEN_W(LW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .w_data(w_data), .w_vld(w_vld), .w_rdy(w_rdy),
    .fm_data(fm_data), .fm_vld(fm_vld), .fm_rdy(fm_rdy),
    .pe_w_data(pe_w_data), .pe_w_valid(pe_w_valid), .pe_fm_data(pe_fm_data),
    .pe_psum(pe_psum), .out_data(out_data), .out_vld(out_vld),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail = 0;
  int              w_m [K];
  logic [DW-1:0]   hist [PL+K-1];
  logic [2*DW-1:0] exp_q [$];
  bit              data_chk = 1'b1;
  int              out_cnt = 0;
  int              done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor plus chain stand-in: psum in cycle c is the window ending at the beat of cycle c-(PL-1).
  always @(negedge clk) begin
    int acc;
    if (out_vld) begin
      out_cnt++;
      if (exp_q.size() > 0) begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        if (data_chk) check("out_data", 32'(out_data), 32'(e));
      end
    end
    if (done) done_cnt++;
    for (int i = PL+K-2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pe_fm_data;
    acc = 0;
    for (int i = 0; i < K; i++) acc += w_m[i] * int'(hist[PL-1+K-1-i]);
    pe_psum = (2*DW)'(acc);
  end

  task automatic check_quiet(input string pre);
    check({pre, "_busy"}, 32'(busy), 0);
    check({pre, "_done"}, 32'(done), 0);
    check({pre, "_err"}, 32'(err), 0);
    check({pre, "_w_rdy"}, 32'(w_rdy), 0);
    check({pre, "_fm_rdy"}, 32'(fm_rdy), 0);
    check({pre, "_pe_w_valid"}, 32'(pe_w_valid), 0);
    check({pre, "_out_vld"}, 32'(out_vld), 0);
    check({pre, "_pe_w_data"}, 32'(pe_w_data), 0);
    check({pre, "_pe_fm_data"}, 32'(pe_fm_data), 0);
    check({pre, "_out_data"}, 32'(out_data), 0);
  endtask

  task automatic illegal_start(input int n);
    start = 1'b1; len = LW'(n);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("illegal_err", 32'(err), 1);
    check("illegal_busy", 32'(busy), 0);
    check("illegal_w_rdy", 32'(w_rdy), 0);
    tick(); tick();
    @(negedge clk);
    check("illegal_stays_idle", 32'(busy), 0);
    tick();
  endtask

  task automatic run_pass(input int n, input bit directed, input bit wstall,
                          input int gap_at, input bit abort);
    int feat [];
    int seq [$];
    int acc, k, i, guard, stall, fmrdy_hi, busy_lo, n_out;
    bit gapped;
    feat = new[n];
    for (int j = 0; j < K; j++) w_m[j] = directed ? j+1 : int'($urandom_range(0, 15));
    for (int j = 0; j < n; j++) feat[j] = directed ? j+1 : int'($urandom_range(0, 255));
    for (int j = 0; j < P; j++) seq.push_back(0);
    for (int j = 0; j < n; j++) seq.push_back(feat[j]);
    for (int j = 0; j < P; j++) seq.push_back(0);
    exp_q.delete();
    for (int j = K-1; j < seq.size(); j++) begin
      acc = 0;
      for (int t = 0; t < K; t++) acc += w_m[t] * seq[j-(K-1)+t];
      exp_q.push_back((2*DW)'(acc));
    end
    n_out = exp_q.size();
    data_chk = (gap_at < 0);
    out_cnt = 0; done_cnt = 0;

    start = 1'b1; len = LW'(n);
    tick();
    start = 1'b0;

    i = 0; guard = 0; stall = 0;
    while (i < K && guard < 50) begin
      if (wstall && i == 1 && stall < 4) begin
        w_vld = 1'b0;
        if (stall == 0) begin start = 1'b1; len = '0; end
        @(negedge clk);
        check("stall_pe_w_valid", 32'(pe_w_valid), 0);
        check("stall_w_rdy", 32'(w_rdy), 1);
        stall++;
      end else begin
        w_vld = 1'b1; w_data = DW'(w_m[i]);
        @(negedge clk);
        if (guard == 0) begin
          check("busy_after_start", 32'(busy), 1);
          check("err_cleared", 32'(err), 0);
        end
        if (w_rdy) begin
          check("pe_w_valid", 32'(pe_w_valid), 32'(1) << i);
          check("pe_w_data", 32'(pe_w_data), 32'(w_m[i]));
          i++;
        end
      end
      guard++;
      tick();
      start = 1'b0;
    end
    w_vld = 1'b0;
    check("weights_loaded", i, K);

    k = 0; guard = 0; gapped = 1'b0;
    while (k < n && guard < 200) begin
      if (k == gap_at && !gapped) begin
        fm_vld = 1'b0; fm_data = 8'hA5;
        @(negedge clk);
        if (fm_rdy) begin
          gapped = 1'b1;
          check("gap_err", 32'(err), 1);
          check("gap_pe_fm_zero", 32'(pe_fm_data), 0);
        end
      end else begin
        fm_vld = 1'b1; fm_data = DW'(feat[k]);
        @(negedge clk);
        if (fm_rdy) begin
          check("pe_fm_data", 32'(pe_fm_data), 32'(feat[k]));
          k++;
        end
      end
      guard++;
      tick();
    end
    fm_vld = 1'b0;
    check("features_consumed", k, n);

    if (abort) begin
      repeat (3) tick();
      @(negedge clk);
      check("busy_pre_abort", 32'(busy), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_quiet("abort");
      exp_q.delete();
      out_cnt = 0; done_cnt = 0;
      tick();
      rst_n = 1'b1;
      repeat (20) tick();
      check("abort_no_out", out_cnt, 0);
      check("abort_no_done", done_cnt, 0);
      check("abort_idle", 32'(busy), 0);
      return;
    end

    guard = 0; fmrdy_hi = 0; busy_lo = 0;
    @(negedge clk);
    while (!done && guard < 100) begin
      if (fm_rdy) fmrdy_hi++;
      if (!busy) busy_lo++;
      @(negedge clk);
      guard++;
    end
    check("done_seen", 32'(done), 1);
    check("drain_len", guard, PL + P);
    check("drain_fm_rdy", fmrdy_hi, 0);
    check("busy_level", busy_lo, 0);
    check("out_vld_at_done", 32'(out_vld), 0);
    check("out_count_at_done", out_cnt, n_out);
    check("exp_remaining", exp_q.size(), 0);
    check("err_final", 32'(err), 32'(gapped));
    tick();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    check("done_count", done_cnt, 1);
    tick();
  endtask

  initial begin
    for (int j = 0; j < PL+K-1; j++) hist[j] = '0;
    for (int j = 0; j < K; j++) w_m[j] = 0;
    #1 rst_n = 1'b0;
    #2 check_quiet("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    run_pass(5, 1'b1, 1'b0, -1, 1'b0);
    illegal_start(P > 0 ? 0 : K-1);
    run_pass(P > 0 ? 1 : K, 1'b0, 1'b0, -1, 1'b0);
    run_pass(int'($urandom_range(6, 20)), 1'b0, 1'b1, -1, 1'b0);
    run_pass(int'($urandom_range(8, 16)), 1'b0, 1'b0, 3, 1'b0);
    run_pass(4, 1'b0, 1'b0, -1, 1'b0);
    for (int r = 0; r < 4; r++) run_pass(int'($urandom_range(K, 24)), 1'b0, 1'b0, -1, 1'b0);
    run_pass(10, 1'b0, 1'b0, -1, 1'b1);
    run_pass(7, 1'b0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
